// File: rtl/data_mem_pkg.sv
// Shared types, default sizes and the byte-masked merge helper for the
// synchronous data memory.
package data_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W    = 256;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]    old_word,
    input logic [MERGE_W-1:0]    new_word,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with one byte-enabled write port and an asynchronous read port.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = 3
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= DATA_W'(be_merge(MERGE_W'(mem[wr_idx]),
                                      MERGE_W'(wr_data),
                                      MERGE_BE_W'(wr_be)));
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_sync.sv
// Synchronous data memory: hardware clear after reset, then one load/store
// per cycle with registered response and out-of-range flagging.
module data_mem_sync
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic              rsp_valid_reg, rsp_err_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  logic              in_range;
  logic              accept;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] rd_data;

  // Full-width compare so addresses that alias onto a valid index are rejected.
  assign in_range = {1'b0, req_addr} < DEPTH_EXT;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    req_ready  = 1'b0;
    init_done  = 1'b0;
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = ptr_reg;
    wr_data    = '0;
    wr_be      = '0;
    case (state_reg)
      INIT: begin
        wr_en    = 1'b1;
        wr_be    = '1;
        ptr_next = ptr_reg + 1'b1;
        if (ptr_reg == LAST_IDX) state_next = RUN;
      end
      RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        accept    = req_valid;
        if (req_valid && req_we && in_range) begin
          wr_en   = 1'b1;
          wr_idx  = req_addr[IDX_W-1:0];
          wr_data = req_wdata;
          wr_be   = req_be;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      ptr_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      rsp_valid_reg <= accept;
      rsp_err_reg   <= accept && !in_range;
      rsp_rdata_reg <= (accept && !req_we && in_range) ? rd_data : '0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

  // A reset edge must not commit any write, including a clear step.
  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en && rst_n),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .rd_idx  (req_addr[IDX_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_data_mem_sync.sv
// Randomised and directed bench for data_mem_sync, running a 16x8 and a 32x16
// instance side by side against a word-array reference model.
module tb_data_mem_sync;

  logic        clk;
  logic        rst_n;
  logic        req_valid0, req_valid1;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        req_ready0, rsp_valid0, rsp_err0, init_done0;
  logic [15:0] rsp_rdata0;
  logic        req_ready1, rsp_valid1, rsp_err1, init_done1;
  logic [31:0] rsp_rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_left [2];
  logic [31:0] mm     [2][16];
  logic        e_v    [2];
  logic        e_err  [2];
  logic [31:0] e_rd   [2];
  int          dep    [2] = '{8, 16};
  logic [31:0] wmask  [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};

  data_mem_sync #(.DATA_W(16), .DEPTH(8), .ADDR_W(16)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata[15:0]),
    .req_be    (req_be[1:0]),
    .rsp_valid (rsp_valid0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0),
    .init_done (init_done0)
  );

  data_mem_sync #(.DATA_W(32), .DEPTH(16), .ADDR_W(16)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid1),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1),
    .init_done (init_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: check ready, drive inputs, advance the model, check responses.
  task automatic cyc(input logic rstn, input logic v0, input logic v1, input logic we,
                     input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [1:0]  vv;
    logic [31:0] mask;
    logic        acc, inr;
    vv = {v1, v0};
    check_val("ready0", 32'(req_ready0), 32'(m_left[0] == 0));
    check_val("ready1", 32'(req_ready1), 32'(m_left[1] == 0));
    rst_n      = rstn;
    req_valid0 = v0;
    req_valid1 = v1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    req_be     = be;
    mask = '0;
    for (int i = 0; i < 4; i++) if (be[i]) mask[8*i +: 8] = 8'hFF;
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        m_left[d] = dep[d];
        e_v[d] = 1'b0; e_err[d] = 1'b0; e_rd[d] = '0;
        for (int k = 0; k < 16; k++) mm[d][k] = '0;
      end else if (m_left[d] > 0) begin
        m_left[d]--;
        e_v[d] = 1'b0; e_err[d] = 1'b0; e_rd[d] = '0;
      end else begin
        acc      = vv[d];
        inr      = int'(addr) < dep[d];
        e_v[d]   = acc;
        e_err[d] = acc && !inr;
        e_rd[d]  = (acc && !we && inr) ? mm[d][int'(addr)] : 32'h0;
        if (acc && we && inr)
          mm[d][int'(addr)] = ((mm[d][int'(addr)] & ~mask) | (wd & mask)) & wmask[d];
      end
    end
    if (rstn && (v0 || v1))
      $display("txn v0=%0d v1=%0d we=%0d addr=%h wdata=%h be=%b", v0, v1, we, addr, wd, be);
    @(posedge clk);
    @(negedge clk);
    check_val("valid0", 32'(rsp_valid0), 32'(e_v[0]));
    check_val("rdata0", 32'(rsp_rdata0), e_rd[0]);
    check_val("err0",   32'(rsp_err0),   32'(e_err[0]));
    check_val("done0",  32'(init_done0), 32'(m_left[0] == 0));
    check_val("valid1", 32'(rsp_valid1), 32'(e_v[1]));
    check_val("rdata1", rsp_rdata1,      e_rd[1]);
    check_val("err1",   32'(rsp_err1),   32'(e_err[1]));
    check_val("done1",  32'(init_done1), 32'(m_left[1] == 0));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_left[d] = dep[d];
      e_v[d] = 1'b0; e_err[d] = 1'b0; e_rd[d] = '0;
      for (int k = 0; k < 16; k++) mm[d][k] = '0;
    end
    rst_n = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready0", 32'(req_ready0), 32'h0);
    check_val("rst_valid0", 32'(rsp_valid0), 32'h0);
    check_val("rst_rdata0", 32'(rsp_rdata0), 32'h0);
    check_val("rst_err0",   32'(rsp_err0),   32'h0);
    check_val("rst_done0",  32'(init_done0), 32'h0);
    check_val("rst_ready1", 32'(req_ready1), 32'h0);

    // Init with a request held: eight refused cycles, then loads of 0..7.
    for (int i = 0; i < 18; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'(i % 8), 32'h0, 4'h0);

    // Byte-enable merge.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 32'hABCD, 4'b0011);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 32'h1234, 4'b0001);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 32'h0, 4'h0);
    check_val("be_merge", 32'(rsp_rdata0), 32'h0000_AB34);

    // Back-to-back stores then loads.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'(i), 32'h1000 + i, 4'b0011);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'(i), 32'h0, 4'h0);
      check_val("pipe_rd", 32'(rsp_rdata0), 32'h1000 + i);
    end

    // Out of range, then confirm address 0 is untouched.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd8, 32'h0, 4'h0);
    check_val("oor_ld_err", 32'(rsp_err0), 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0008, 32'hFFFF, 4'b0011);
    check_val("oor_st_err", 32'(rsp_err0), 32'h1);
    check_val("oor_st_rd",  32'(rsp_rdata0), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
    check_val("no_alias", 32'(rsp_rdata0), 32'h1000);

    // Wide instance: byte-enabled store to the last word.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'd15, 32'hDEAD_BEEF, 4'b0101);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'd15, 32'h0, 4'h0);
    check_val("sweep_rd", rsp_rdata1, 32'h00AD_00EF);

    // Randomised traffic with occasional resets and aliasing addresses.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      cyc(($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
          a, $urandom, 4'($urandom));
    end

    // Reset right after accepting a load: response dropped, array re-cleared.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'(i), 32'hA5A5_5A5A, 4'hF);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 32'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 32'h0, 4'h0);
    check_val("rst_drop", 32'(rsp_valid0), 32'h0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'(i), 32'h0, 4'h0);
      check_val("reinit_rd", 32'(rsp_rdata0), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
